unet_map_dispatch: RTL and testbench



---
 rtl/unet_map_dispatch_if.sv | 26 ++
 rtl/unet_map_dispatch.sv | 196 +++++++++++++++++++
 tb/tb_unet_map_dispatch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/unet_map_dispatch_if.sv
// Bundle between the mapping-pointer dispatch engine, the base-address BRAM
// and the NFC command port. The engine side is master; BRAM/NFC side is slave.
interface unet_map_dispatch_if #(
  parameter int NUM_WAYS   = 8,
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           ram_addr;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [NUM_WAYS-1:0]   nfc_busy;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_way;
  logic [DATA_WIDTH-1:0] cmd_row;
  logic                  cmd_done;

  modport master (
    output ram_addr, ram_en, cmd_valid, cmd_way, cmd_row,
    input  ram_rd_data, nfc_busy, cmd_ready, cmd_done
  );

  modport slave (
    input  ram_addr, ram_en, cmd_valid, cmd_way, cmd_row,
    output ram_rd_data, nfc_busy, cmd_ready, cmd_done
  );
endinterface

// File: rtl/unet_map_dispatch.sv
// Fetches patches of mapping pointers from BRAM, decodes them into way/row
// commands, queues them and dispatches each one once its target way is free.
module unet_map_dispatch #(
  parameter int          NUM_WAYS          = 8,
  parameter int          DATA_WIDTH        = 32,
  parameter logic [31:0] START_ADDR        = 32'h4580_0000,
  parameter int          ENTRIES_PER_PATCH = 16,
  parameter int          PATCHES           = 2,
  parameter int          FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  unet_map_dispatch_if.master          bus,
  output logic                         uw_busy,
  output logic                         uw_ready,
  output logic                         module_finish,
  output logic [$clog2(PATCHES+1)-1:0] patch_num,
  output logic                         map_error
);

  localparam int CW   = $clog2(ENTRIES_PER_PATCH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int PW   = $clog2(PATCHES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]       done_cnt_q, done_cnt_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic                rd_vld_q, rd_vld_d;
  logic [PW-1:0]       patch_q, patch_d;
  logic                finish_q, finish_d;
  logic                run_busy_q, run_busy_d;
  logic                err_q, err_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [NUM_WAYS-1:0] nfc_busy_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic [3:0]            in_way;
  logic [3:0]            head_way;
  logic [15:0]           way_blocked;
  logic                  in_way_ok;
  logic                  push;
  logic                  bad;
  logic                  pop;
  logic                  fifo_empty;
  logic                  cmd_valid_w;
  logic                  done_ok;
  logic                  room;
  logic                  rd_fire;

  // Ways beyond NUM_WAYS never reach the FIFO; treat them as permanently busy.
  for (genvar gi = 0; gi < 16; gi++) begin : g_way_blocked
    if (gi < NUM_WAYS) begin : g_real
      assign way_blocked[gi] = nfc_busy_q[gi];
    end else begin : g_absent
      assign way_blocked[gi] = 1'b1;
    end
  end

  assign in_way      = bus.ram_rd_data[DATA_WIDTH-1 -: 4];
  assign in_way_ok   = 32'(in_way) < 32'(NUM_WAYS);
  assign push        = rd_vld_q && in_way_ok;
  assign bad         = rd_vld_q && !in_way_ok;
  assign head        = mem[rd_ptr_q];
  assign head_way    = head[DATA_WIDTH-1 -: 4];
  assign fifo_empty  = (count_q == '0);
  assign cmd_valid_w = !fifo_empty && !way_blocked[head_way];
  assign pop         = cmd_valid_w && bus.cmd_ready;
  assign done_ok     = bus.cmd_done && (outst_q != '0);
  // The read in flight already has a FIFO slot reserved, so a push never overflows.
  assign room        = (32'(count_q) + 32'(rd_vld_q)) < 32'(FIFO_DEPTH);
  assign rd_fire     = (state_q == S_FETCH) && room;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.ram_rd_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    patch_d    = patch_q;
    finish_d   = finish_q;
    run_busy_d = run_busy_q;
    rd_vld_d   = rd_fire;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CNTW'(push) - CNTW'(pop);
    outst_d    = outst_q + CW'(pop) - CW'(done_ok);
    done_cnt_d = done_cnt_q + CW'(done_ok) + CW'(bad);
    err_d      = err_q | bad;

    if (rd_fire) begin
      addr_d   = addr_q + 32'd4;
      rd_cnt_d = rd_cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          addr_d     = START_ADDR;
          rd_cnt_d   = '0;
          done_cnt_d = '0;
          outst_d    = '0;
          patch_d    = '0;
          finish_d   = 1'b0;
          err_d      = 1'b0;
          run_busy_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (rd_fire && (rd_cnt_q == CW'(ENTRIES_PER_PATCH - 1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done_cnt_q == CW'(ENTRIES_PER_PATCH)) begin
          patch_d    = patch_q + PW'(1);
          done_cnt_d = '0;
          rd_cnt_d   = '0;
          if ((32'(patch_q) + 32'd1) < 32'(PATCHES)) begin
            state_d = S_FETCH;
          end else begin
            state_d    = S_DONE;
            finish_d   = 1'b1;
            run_busy_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      done_cnt_q <= '0;
      outst_q    <= '0;
      rd_vld_q   <= 1'b0;
      patch_q    <= '0;
      finish_q   <= 1'b0;
      run_busy_q <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      nfc_busy_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      done_cnt_q <= done_cnt_d;
      outst_q    <= outst_d;
      rd_vld_q   <= rd_vld_d;
      patch_q    <= patch_d;
      finish_q   <= finish_d;
      run_busy_q <= run_busy_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      nfc_busy_q <= bus.nfc_busy;
    end
  end

  // Head payload only moves on a pop, so it is stable while a command waits.
  assign bus.ram_addr  = addr_q;
  assign bus.ram_en    = rd_fire;
  assign bus.cmd_valid = cmd_valid_w;
  assign bus.cmd_way   = fifo_empty ? 4'd0 : head_way;
  assign bus.cmd_row   = fifo_empty ? '0 : {4'b0, head[DATA_WIDTH-5:0]};
  assign uw_busy       = run_busy_q;
  assign uw_ready      = (state_q == S_IDLE);
  assign module_finish = finish_q;
  assign patch_num     = patch_q;
  assign map_error     = err_q;

endmodule

// File: tb/tb_unet_map_dispatch.sv
// Directed bench for unet_map_dispatch: BRAM model, delayed cmd_done responder
// and an in-order scoreboard of expected way/row commands.
module tb_unet_map_dispatch;

  localparam logic [31:0] START = 32'h4580_0000;
  localparam int EPP = 8;
  localparam int NP  = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        uw_busy;
  logic        uw_ready;
  logic        module_finish;
  logic [1:0]  patch_num;
  logic        map_error;

  unet_map_dispatch_if #(.NUM_WAYS(8), .DATA_WIDTH(32)) bus ();

  unet_map_dispatch #(
    .NUM_WAYS(8), .DATA_WIDTH(32), .START_ADDR(START),
    .ENTRIES_PER_PATCH(EPP), .PATCHES(NP), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .uw_busy(uw_busy), .uw_ready(uw_ready), .module_finish(module_finish),
    .patch_num(patch_num), .map_error(map_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ptr_table [64];
  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_rd_data <= ptr_table[6'((bus.ram_addr - START) >> 2)];
  end

  int          checks;
  int          errors;
  int          rd_total;
  int          acc_total;
  int          base_rd;
  int          base_acc;
  logic        spurious;
  logic [2:0]  done_sr;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts reads and accepts, answers each accept with cmd_done and checks order.
  task automatic bg_loop();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.ram_en) rd_total++;
      if (rst) done_sr = '0;
      else done_sr = {done_sr[1:0], bus.cmd_valid && bus.cmd_ready};
      bus.cmd_done = done_sr[2] | spurious;
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          chk("cmd_unexpected", 32'(bus.cmd_way), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_way", 32'(bus.cmd_way), 32'(e[31:28]));
          chk("cmd_row", bus.cmd_row, {4'h0, e[27:0]});
        end
        $display("cmd accept: way=%0d row=%h", bus.cmd_way, bus.cmd_row);
      end
    end
  endtask

  task automatic load_table(input int kind);
    for (int i = 0; i < 64; i++) begin
      logic [31:0] p;
      p = {4'(i % 7 + 1), 28'((i + 1) * 16)};
      if (kind == 1 && i == 2) p = 32'hF000_0005;
      if (kind == 2 && i == 0) p = 32'h3000_0ABC;
      ptr_table[i] = p;
      if (i < EPP * NP && p[31:28] < 4'd8) exp_q.push_back(p);
    end
    base_rd  = rd_total;
    base_acc = acc_total;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ram_addr"}, bus.ram_addr, 32'h0);
    chk({tag, "_ram_en"}, 32'(bus.ram_en), 32'h0);
    chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'h0);
    chk({tag, "_cmd_way"}, 32'(bus.cmd_way), 32'h0);
    chk({tag, "_cmd_row"}, bus.cmd_row, 32'h0);
    chk({tag, "_uw_busy"}, 32'(uw_busy), 32'h0);
    chk({tag, "_uw_ready"}, 32'(uw_ready), 32'h1);
    chk({tag, "_finish"}, 32'(module_finish), 32'h0);
    chk({tag, "_patch_num"}, 32'(patch_num), 32'h0);
    chk({tag, "_map_error"}, 32'(map_error), 32'h0);
  endtask

  task automatic wait_finish(input string tag, input int n_cmds);
    for (int n = 0; n < 400 && !module_finish; n++) step();
    chk({tag, "_finish"}, 32'(module_finish), 32'h1);
    chk({tag, "_patch_num"}, 32'(patch_num), NP);
    chk({tag, "_uw_busy"}, 32'(uw_busy), 32'h0);
    repeat (4) step();
    chk({tag, "_accepts"}, 32'(acc_total - base_acc), 32'(n_cmds));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    $display("run %s: %0d commands accepted", tag, acc_total - base_acc);
  endtask

  initial begin
    checks = 0; errors = 0; rd_total = 0; acc_total = 0;
    base_rd = 0; base_acc = 0; done_sr = '0;
    rst = 1'b1; start = 1'b0; spurious = 1'b0;
    bus.cmd_ready = 1'b1; bus.nfc_busy = '0; bus.cmd_done = 1'b0;
    fork
      bg_loop();
    join_none
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    // Normal run: latency, address order, patch stepping, finish handshake
    load_table(0);
    pulse_start();
    chk("c1_ram_en", 32'(bus.ram_en), 32'h1);
    chk("c1_ram_addr", bus.ram_addr, START);
    chk("c1_uw_busy", 32'(uw_busy), 32'h1);
    chk("c1_uw_ready", 32'(uw_ready), 32'h0);
    step();
    chk("c2_ram_addr", bus.ram_addr, START + 32'd4);
    chk("c2_cmd_valid", 32'(bus.cmd_valid), 32'h0);
    step();
    chk("c3_cmd_valid", 32'(bus.cmd_valid), 32'h1);
    chk("c3_cmd_way", 32'(bus.cmd_way), 32'h1);
    chk("c3_cmd_row", bus.cmd_row, 32'h10);
    for (int n = 0; n < 200 && patch_num != 2'd1; n++) step();
    chk("patch1", 32'(patch_num), 32'h1);
    chk("patch1_finish", 32'(module_finish), 32'h0);
    chk("patch1_busy", 32'(uw_busy), 32'h1);
    for (int n = 0; n < 200 && !module_finish; n++) step();
    chk("done_uw_ready", 32'(uw_ready), 32'h0);
    step();
    chk("idle_uw_ready", 32'(uw_ready), 32'h1);
    wait_finish("normal", 16);

    // Spurious completion while idle
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    repeat (3) step();
    chk("spur_patch_num", 32'(patch_num), NP);
    chk("spur_finish", 32'(module_finish), 32'h1);

    // Invalid way pointer
    load_table(1);
    pulse_start();
    chk("inv_finish_cleared", 32'(module_finish), 32'h0);
    chk("inv_patch_cleared", 32'(patch_num), 32'h0);
    wait_finish("invalid", 15);
    chk("inv_map_error", 32'(map_error), 32'h1);

    // Busy way 3 at the FIFO head
    load_table(2);
    bus.nfc_busy = 8'h08;
    pulse_start();
    chk("busy_err_cleared", 32'(map_error), 32'h0);
    repeat (2) step();
    for (int n = 0; n < 20; n++) begin
      chk("busy_valid", 32'(bus.cmd_valid), 32'h0);
      chk("busy_way", 32'(bus.cmd_way), 32'h3);
      chk("busy_row", bus.cmd_row, 32'hABC);
      step();
    end
    chk("busy_reads", 32'(rd_total - base_rd), 32'h4);
    bus.nfc_busy = 8'h00;
    #2;
    chk("busy_clear_same", 32'(bus.cmd_valid), 32'h0);
    step();
    chk("busy_clear_next", 32'(bus.cmd_valid), 32'h1);
    chk("busy_clear_way", 32'(bus.cmd_way), 32'h3);
    wait_finish("busy", 16);

    // Backpressure via cmd_ready
    bus.cmd_ready = 1'b0;
    load_table(0);
    pulse_start();
    repeat (12) step();
    chk("bp_reads", 32'(rd_total - base_rd), 32'h4);
    chk("bp_accepts", 32'(acc_total - base_acc), 32'h0);
    chk("bp_valid", 32'(bus.cmd_valid), 32'h1);
    bus.cmd_ready = 1'b1;
    wait_finish("backpressure", 16);

    // Ignored second start, then reset in DRAIN and replay
    load_table(0);
    pulse_start();
    step();
    pulse_start();
    for (int n = 0; n < 100 && (rd_total - base_rd) < EPP; n++) step();
    chk("drain_ram_en", 32'(bus.ram_en), 32'h0);
    chk("drain_ram_addr", bus.ram_addr, START + 32'(4 * EPP));
    chk("drain_busy", 32'(uw_busy), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    step();
    rst = 1'b0;
    exp_q.delete();
    step();
    load_table(0);
    pulse_start();
    chk("replay_ram_en", 32'(bus.ram_en), 32'h1);
    chk("replay_ram_addr", bus.ram_addr, START);
    wait_finish("replay", 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
